// File: rtl/cpu_pkg.sv
// Shared widths, ALU operation codes and controller opcode fields for the
// 4-bit accumulator CPU.
package cpu_pkg;

    localparam int DATA_W    = 4;
    localparam int ADDR_W    = 8;
    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b1000;
    localparam logic [3:0] ALU_SHR = 4'b1100;
    localparam logic [3:0] ALU_SHL = 4'b1101;

    // Upper-nibble opcode fields decoded by the controller from opcode[7:4]
    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_LDI  = 4'h1;
    localparam logic [3:0] OPC_LDR  = 4'h2;
    localparam logic [3:0] OPC_STR  = 4'h3;
    localparam logic [3:0] OPC_ALU  = 4'h4;
    localparam logic [3:0] OPC_JMPI = 4'h5;
    localparam logic [3:0] OPC_JMPR = 4'h6;
    localparam logic [3:0] OPC_BZ   = 4'h7;
    localparam logic [3:0] OPC_BC   = 4'h8;

    function automatic logic [ADDR_W-1:0] zext_addr(input logic [DATA_W-1:0] v);
        return {{(ADDR_W-DATA_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 4-bit ALU; unlisted operations pass operand a through and
// return the incoming carry so the flag is left untouched.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    input  logic              cin,
    output logic [DATA_W-1:0] r,
    output logic              cout
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    // The extra MSB of the difference is the borrow: set exactly when a < b
    assign w_diff = {1'b0, a} - {1'b0, b};

    // Operation select
    always_comb begin
        r    = a;
        cout = cin;
        case (op)
            ALU_ADD: begin
                r    = w_sum[DATA_W-1:0];
                cout = w_sum[DATA_W];
            end
            ALU_SUB: begin
                r    = w_diff[DATA_W-1:0];
                cout = w_diff[DATA_W];
            end
            ALU_NOR: begin
                r    = ~(a | b);
                cout = 1'b0;
            end
            ALU_SHR: begin
                r    = {1'b0, a[DATA_W-1:1]};
                cout = a[0];
            end
            ALU_SHL: begin
                r    = {a[DATA_W-2:0], 1'b0};
                cout = a[DATA_W-1];
            end
            default: begin
                r    = a;
                cout = cin;
            end
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: PC, IR, 16x4 register file, accumulator, carry
// flag and sticky strobe-protocol error flag, all driven by controller strobes.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    instr_data,
    input  logic                 load_ir,
    input  logic                 inc_pc,
    input  logic                 sel_pc,
    input  logic                 load_pc,
    input  logic                 load_reg,
    input  logic                 dump_reg,
    input  logic                 load_acc,
    input  logic                 dump_acc,
    input  logic                 sel_acc0,
    input  logic                 sel_acc1,
    input  logic [3:0]           sel_alu,
    input  logic [DATA_W-1:0]    imm_data,
    input  logic [REG_IDX_W-1:0] reg_number,
    output logic [ADDR_W-1:0]    pc,
    output logic [ADDR_W-1:0]    opcode,
    output logic                 zero_carry,
    output logic                 acc_zero,
    output logic [DATA_W-1:0]    acc,
    output logic                 proto_err
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ir;
    logic [DATA_W-1:0] r_acc;
    logic              r_carry;
    logic              r_proto_err;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic [DATA_W-1:0] w_reg_rd;
    logic [DATA_W-1:0] w_alu_r;
    logic              w_alu_c;
    logic [DATA_W-1:0] w_acc_nxt;
    logic [ADDR_W-1:0] w_pc_src;
    logic              w_viol;

    // All reads see pre-edge register contents, so same-cycle writes never bypass
    assign w_reg_rd = r_regs[reg_number];

    cpu_alu u_alu (
        .a    (r_acc),
        .b    (w_reg_rd),
        .op   (sel_alu),
        .cin  (r_carry),
        .r    (w_alu_r),
        .cout (w_alu_c)
    );

    // Accumulator source select and jump-target select
    always_comb begin
        w_acc_nxt = imm_data;
        if (sel_acc1) begin
            w_acc_nxt = w_alu_r;
        end else if (sel_acc0) begin
            w_acc_nxt = w_reg_rd;
        end else begin
            w_acc_nxt = imm_data;
        end
        w_pc_src = sel_pc ? zext_addr(imm_data) : zext_addr(w_reg_rd);
    end

    assign w_viol = (load_pc & inc_pc) | (load_reg & ~dump_acc) |
                    (dump_reg & dump_acc) | (load_acc & load_reg);

    // Program counter and instruction register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= 8'h00;
            r_ir <= 8'h00;
        end else begin
            if (load_pc) begin
                r_pc <= w_pc_src;
            end else if (inc_pc) begin
                r_pc <= r_pc + 8'h01;
            end else begin
                r_pc <= r_pc;
            end
            if (load_ir) begin
                r_ir <= instr_data;
            end else begin
                r_ir <= r_ir;
            end
        end
    end

    // Accumulator and carry flag; carry moves only on an ALU result load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= 4'h0;
            r_carry <= 1'b0;
        end else if (load_acc) begin
            r_acc   <= w_acc_nxt;
            r_carry <= sel_acc1 ? w_alu_c : r_carry;
        end else begin
            r_acc   <= r_acc;
            r_carry <= r_carry;
        end
    end

    // Register file write port
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 4'h0;
            end
        end else if (load_reg && dump_acc) begin
            r_regs[reg_number] <= r_acc;
        end else begin
            r_regs[reg_number] <= r_regs[reg_number];
        end
    end

    // Sticky protocol-violation flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= r_proto_err | w_viol;
        end
    end

    assign pc         = r_pc;
    assign opcode     = r_ir;
    assign acc        = r_acc;
    assign zero_carry = r_carry;
    assign proto_err  = r_proto_err;
    assign acc_zero   = (r_acc == 4'h0);

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath with hand-computed expectations.
module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instr_data;
    logic       load_ir, inc_pc, sel_pc, load_pc, load_reg, dump_reg;
    logic       load_acc, dump_acc, sel_acc0, sel_acc1;
    logic [3:0] sel_alu, imm_data, reg_number;
    logic [7:0] pc, opcode;
    logic       zero_carry, acc_zero, proto_err;
    logic [3:0] acc;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_datapath dut (
        .clk(clk), .reset(reset), .instr_data(instr_data),
        .load_ir(load_ir), .inc_pc(inc_pc), .sel_pc(sel_pc), .load_pc(load_pc),
        .load_reg(load_reg), .dump_reg(dump_reg), .load_acc(load_acc),
        .dump_acc(dump_acc), .sel_acc0(sel_acc0), .sel_acc1(sel_acc1),
        .sel_alu(sel_alu), .imm_data(imm_data), .reg_number(reg_number),
        .pc(pc), .opcode(opcode), .zero_carry(zero_carry), .acc_zero(acc_zero),
        .acc(acc), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        reset = 1'b0; instr_data = 8'h00;
        load_ir = 1'b0; inc_pc = 1'b0; sel_pc = 1'b0; load_pc = 1'b0;
        load_reg = 1'b0; dump_reg = 1'b0; load_acc = 1'b0; dump_acc = 1'b0;
        sel_acc0 = 1'b0; sel_acc1 = 1'b0;
        sel_alu = 4'h0; imm_data = 4'h0; reg_number = 4'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
    endtask

    task automatic ld_imm(input logic [3:0] v);
        load_acc = 1'b1; imm_data = v;
        tick();
    endtask

    task automatic st_reg(input logic [3:0] n);
        load_reg = 1'b1; dump_acc = 1'b1; reg_number = n;
        tick();
    endtask

    task automatic ld_reg(input logic [3:0] n);
        load_acc = 1'b1; sel_acc0 = 1'b1; reg_number = n;
        tick();
    endtask

    task automatic alu(input logic [3:0] op, input logic [3:0] n);
        load_acc = 1'b1; sel_acc1 = 1'b1; sel_alu = op; reg_number = n;
        tick();
    endtask

    initial begin
        clr();
        // Reset state
        do_reset();
        check("rst_pc", pc, 8'h00);
        check("rst_opcode", opcode, 8'h00);
        check("rst_acc", {4'h0, acc}, 8'h00);
        check("rst_carry", {7'h0, zero_carry}, 8'h00);
        check("rst_perr", {7'h0, proto_err}, 8'h00);
        check("rst_acc_zero", {7'h0, acc_zero}, 8'h01);

        // Immediate load, store, read back
        ld_imm(4'h9);
        check("ldi_acc", {4'h0, acc}, 8'h09);
        check("ldi_acc_zero", {7'h0, acc_zero}, 8'h00);
        st_reg(4'h3);
        ld_imm(4'h0);
        ld_reg(4'h3);
        check("reg3_readback", {4'h0, acc}, 8'h09);
        check("no_perr_normal", {7'h0, proto_err}, 8'h00);

        // ADD / SUB with carry and borrow
        ld_imm(4'h7); st_reg(4'h2); ld_imm(4'hC);
        alu(4'b0000, 4'h2);
        check("add_acc", {4'h0, acc}, 8'h03);
        check("add_carry", {7'h0, zero_carry}, 8'h01);
        alu(4'b0001, 4'h2);
        check("sub_acc", {4'h0, acc}, 8'h0C);
        check("sub_borrow", {7'h0, zero_carry}, 8'h01);
        alu(4'b0010, 4'h2);
        check("pass_acc", {4'h0, acc}, 8'h0C);
        check("pass_carry", {7'h0, zero_carry}, 8'h01);
        ld_imm(4'h1);
        alu(4'b0001, 4'h3);
        check("sub_neg_acc", {4'h0, acc}, 8'h08);
        alu(4'b0000, 4'h2);
        check("add_nc_acc", {4'h0, acc}, 8'h0F);
        check("add_nc_carry", {7'h0, zero_carry}, 8'h00);
        // Carry holds when ALU not loaded into acc
        ld_imm(4'hF);
        sel_acc1 = 1'b1; sel_alu = 4'b0000; reg_number = 4'h2;
        tick();
        check("carry_hold", {7'h0, zero_carry}, 8'h00);
        check("acc_hold", {4'h0, acc}, 8'h0F);

        // PC increment, wrap, jumps
        for (int i = 0; i < 255; i++) begin
            inc_pc = 1'b1;
            tick();
        end
        check("pc_ff", pc, 8'hFF);
        inc_pc = 1'b1; tick();
        check("pc_wrap", pc, 8'h00);
        load_pc = 1'b1; sel_pc = 1'b1; imm_data = 4'h5; tick();
        check("jmp_imm", pc, 8'h05);
        load_pc = 1'b1; sel_pc = 1'b0; reg_number = 4'h3; tick();
        check("jmp_reg", pc, 8'h09);
        check("ir_hold_perr0", {7'h0, proto_err}, 8'h00);
        load_pc = 1'b1; inc_pc = 1'b1; sel_pc = 1'b1; imm_data = 4'h2; tick();
        check("jmp_over_inc", pc, 8'h02);
        check("perr_ld_inc", {7'h0, proto_err}, 8'h01);
        tick();
        check("perr_sticky", {7'h0, proto_err}, 8'h01);

        // Jump-reg sees the old register value on a same-cycle write
        do_reset();
        check("perr_cleared", {7'h0, proto_err}, 8'h00);
        ld_imm(4'h5);
        load_reg = 1'b1; dump_acc = 1'b1; reg_number = 4'h6;
        load_pc = 1'b1; sel_pc = 1'b0;
        tick();
        check("jmp_old_reg", pc, 8'h00);
        load_pc = 1'b1; sel_pc = 1'b0; reg_number = 4'h6; tick();
        check("jmp_new_reg", pc, 8'h05);

        // Shifts and NOR
        ld_imm(4'h7); st_reg(4'h7); ld_imm(4'h9);
        alu(4'b1100, 4'h7);
        check("shr_acc", {4'h0, acc}, 8'h04);
        check("shr_carry", {7'h0, zero_carry}, 8'h01);
        alu(4'b1101, 4'h7);
        check("shl_acc", {4'h0, acc}, 8'h08);
        check("shl_carry", {7'h0, zero_carry}, 8'h00);
        alu(4'b1000, 4'h7);
        check("nor_acc", {4'h0, acc}, 8'h00);
        check("nor_acc_zero", {7'h0, acc_zero}, 8'h01);
        check("nor_carry", {7'h0, zero_carry}, 8'h00);
        ld_imm(4'hA);
        alu(4'b1101, 4'h7);
        check("shl_c1_acc", {4'h0, acc}, 8'h04);
        check("shl_c1_carry", {7'h0, zero_carry}, 8'h01);
        check("perr_clean", {7'h0, proto_err}, 8'h00);

        // Same-cycle swap of acc and reg[4]
        ld_imm(4'h6); st_reg(4'h4); ld_imm(4'h2);
        load_reg = 1'b1; dump_acc = 1'b1; load_acc = 1'b1; sel_acc0 = 1'b1; reg_number = 4'h4;
        tick();
        check("swap_acc", {4'h0, acc}, 8'h06);
        check("swap_perr", {7'h0, proto_err}, 8'h01);
        ld_reg(4'h4);
        check("swap_reg4", {4'h0, acc}, 8'h02);

        // Remaining protocol violations, each from a clean reset
        do_reset();
        load_reg = 1'b1; reg_number = 4'h1; tick();
        check("perr_ldreg_nodump", {7'h0, proto_err}, 8'h01);
        do_reset();
        dump_reg = 1'b1; dump_acc = 1'b1; tick();
        check("perr_dump_both", {7'h0, proto_err}, 8'h01);

        // IR load/hold and reset overriding strobes
        do_reset();
        load_ir = 1'b1; instr_data = 8'h4A; tick();
        check("ir_load", opcode, 8'h4A);
        instr_data = 8'h33; tick();
        check("ir_hold", opcode, 8'h4A);
        ld_imm(4'hB); st_reg(4'h4); inc_pc = 1'b1; tick();
        reset = 1'b1; load_ir = 1'b1; instr_data = 8'h77; load_acc = 1'b1; imm_data = 4'h5;
        inc_pc = 1'b1;
        tick();
        check("rst_ovr_opcode", opcode, 8'h00);
        check("rst_ovr_acc", {4'h0, acc}, 8'h00);
        check("rst_ovr_pc", pc, 8'h00);
        check("rst_ovr_acc_zero", {7'h0, acc_zero}, 8'h01);
        ld_imm(4'h1);
        ld_reg(4'h4);
        check("rst_clears_regs", {4'h0, acc}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port instr_data, input, 8 bits: program memory word at address pc.
REQ-004 The block SHALL have strobe inputs load_ir, inc_pc, sel_pc, load_pc, load_reg, dump_reg, load_acc, dump_acc, sel_acc0 and sel_acc1, each 1 bit, driven by the controller.
REQ-005 The block SHALL have port sel_alu, input, 4 bits: ALU operation code.
REQ-006 The block SHALL have port imm_data, input, 4 bits: immediate operand.
REQ-007 The block SHALL have port reg_number, input, 4 bits: register file index.
REQ-008 The block SHALL have port pc, output, 8 bits: program counter, the program memory address.
REQ-009 The block SHALL have port opcode, output, 8 bits: instruction register (IR) contents, fed back to the controller.
REQ-010 The block SHALL have port zero_carry, output, 1 bit: carry flag register.
REQ-011 The block SHALL have port acc_zero, output, 1 bit: high when acc == 0, combinational from acc.
REQ-012 The block SHALL have port acc, output, 4 bits: accumulator value.
REQ-013 The block SHALL have port proto_err, output, 1 bit: sticky strobe-protocol violation flag.

Function
REQ-014 IR SHALL load instr_data on the clock edge of any cycle with load_ir=1, and SHALL hold otherwise.
REQ-015 PC update priority SHALL be load_pc over inc_pc over hold; inc_pc wraps 8'hFF to 8'h00.
REQ-016 On load_pc the PC source SHALL be zero-extended reg[reg_number] when sel_pc=0, and zero-extended imm_data when sel_pc=1.
REQ-017 The register file SHALL be 16 x 4 bits; reg[reg_number] <= acc when load_reg=1 and dump_acc=1.
REQ-018 The accumulator input mux SHALL select: sel_acc1=1 -> ALU result; else sel_acc0=1 -> reg[reg_number]; else imm_data.
REQ-019 acc SHALL load the mux output when load_acc=1 and hold otherwise.
REQ-020 ALU operand a SHALL be acc and operand b SHALL be reg[reg_number]; the result is 4 bits plus a carry-out.
REQ-021 sel_alu 0000 SHALL compute add: {c,r} = a+b.
REQ-022 sel_alu 0001 SHALL compute sub: r = a-b, with c = borrow (1 when a<b).
REQ-023 sel_alu 1000 SHALL compute nor: r = ~(a|b), with c = 0.
REQ-024 sel_alu 1100 SHALL compute shift right: r = a>>1, with c = a[0].
REQ-025 sel_alu 1101 SHALL compute shift left: r = a<<1, with c = a[3].
REQ-026 Any other sel_alu value SHALL give r = a with the carry unchanged.
REQ-027 The carry flag SHALL update only when load_acc=1 and sel_acc1=1; it holds otherwise.
REQ-028 Simultaneous events SHALL use pre-edge values: a register write in the same cycle as an acc load writes the old acc.
REQ-029 An acc load that reads reg[k] in the same cycle as a write to reg[k] SHALL receive the old reg[k].
REQ-030 A jump-reg using reg[k] in the same cycle as a write to reg[k] SHALL use the old reg[k].
REQ-031 proto_err SHALL set on the clock edge following any cycle with (load_pc & inc_pc), (load_reg & ~dump_acc), (dump_reg & dump_acc), or (load_acc & load_reg).
REQ-032 proto_err SHALL clear only on reset; an offending cycle's other strobes SHALL still execute per REQ-014..REQ-030.
REQ-033 All state-to-output latency SHALL be 1 cycle (registered), except acc_zero, which is combinational from acc.

Reset
REQ-034 With reset=1 at a clock edge, the block SHALL set pc=0, opcode=0, acc=0, zero_carry=0, proto_err=0 and all 16 registers to 0.
REQ-035 reset SHALL override every strobe in the same cycle.
REQ-036 reset asserted mid-instruction SHALL discard any pending update.

Structure
REQ-037 Shared package cpu_pkg SHALL hold the data width (4), address width (8), register count (16) and ALU op constants ALU_ADD/ALU_SUB/ALU_NOR/ALU_SHR/ALU_SHL.
REQ-038 Shared package cpu_pkg SHALL hold the opcode-field constants for the upper nibble used by the controller.
REQ-039 The ALU SHALL be a combinational sub-module cpu_alu (inputs a, b, op, cin; outputs r, cout).
REQ-040 The register file, PC, IR, acc, flag and error logic SHALL reside in cpu_datapath.

Verification
REQ-041 Scenario: reset, then imm_data=4'h9 with load_acc=1 and sel_acc0=sel_acc1=0 -> acc=9 next cycle; then load_reg=1, dump_acc=1, reg_number=3 -> reg[3]=9.
REQ-042 Scenario: acc=4'hC, reg[2]=4'h7, sel_alu=0000, sel_acc1=1, load_acc=1 -> acc=3, zero_carry=1; then sel_alu=0001 with reg[2]=7 -> acc=C, zero_carry=1.
REQ-043 Scenario: pc=8'hFF with inc_pc=1 -> pc=00; load_pc=1, sel_pc=1, imm_data=5 -> pc=05; load_pc=1 and inc_pc=1 together -> load wins and proto_err=1.
REQ-044 Scenario: acc=4'b1001 with SHR -> acc=0100, zero_carry=1; then SHL -> acc=1000, zero_carry=0; then NOR with reg=0111 -> acc=0000, acc_zero=1, zero_carry=0.
REQ-045 Scenario: same cycle load_reg=1, dump_acc=1, load_acc=1, sel_acc0=1, reg_number=4 with acc=2 and reg[4]=6 -> acc=6, reg[4]=2, proto_err=1.
REQ-046 Scenario: load_ir=1 with instr_data=8'h4A -> opcode=4A; reset asserted together with load_ir and load_acc -> all outputs 0.
